// File: rtl/hedios_reg_readback.sv
// Readback path for a bank of HEDIOS registers: snapshots one register plus its
// race flag on request and streams a header byte followed by the value, MSB byte first.
//
// state  | meaning
// S_IDLE | waiting for a read request, req_ready=1
// S_HDR  | presenting the status header byte
// S_DATA | presenting value bytes, r_cnt bytes remain after the current one
module hedios_reg_readback #(
  parameter int DEPTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [NUM_REGS*DEPTH-1:0] reg_bus,
  input  logic [NUM_REGS-1:0]       reg_race,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy
);

  localparam int NBYTES = (DEPTH + 7) / 8;
  localparam int VAL_W  = NBYTES * 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t              r_state;
  logic [VAL_W-1:0]    r_value;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_bad;
  logic [NUM_REGS-1:0] r_race_st;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;

  logic [DEPTH-1:0]    w_sel;
  logic                w_hit;
  logic                w_race;
  logic [NUM_REGS-1:0] w_clr;
  logic [VAL_W-1:0]    w_value_shl;
  logic [5:0]          w_addr6;

  // Out-of-range addresses never match, so they read as bad with no race.
  always_comb begin
    w_sel  = '0;
    w_hit  = 1'b0;
    w_race = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        w_sel  = reg_bus[i*DEPTH +: DEPTH];
        w_hit  = 1'b1;
        w_race = r_race_st[i] | reg_race[i];
      end
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_clr[i] = (r_state == S_HDR) && tx_ready && (r_addr == ADDR_W'(i));
    end
  end

  assign w_value_shl = r_value << 8;
  assign w_addr6     = 6'(req_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_value    <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_bad      <= 1'b0;
      r_race_st  <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      // A new pulse in the clearing cycle keeps the flag set.
      r_race_st <= (r_race_st & ~w_clr) | reg_race;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_value    <= VAL_W'(w_sel);
            r_bad      <= ~w_hit;
            r_tx_data  <= {w_race & w_hit, ~w_hit, w_addr6};
            r_tx_valid <= 1'b1;
            r_state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            if (r_bad) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt     <= CNT_W'(NBYTES - 1);
              r_tx_data <= r_value[VAL_W-1 -: 8];
              r_state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tx_ready) begin
            if (r_cnt == '0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt     <= r_cnt - 1'b1;
              r_value   <= w_value_shl;
              r_tx_data <= w_value_shl[VAL_W-1 -: 8];
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_hedios_reg_readback.sv
// Bench for hedios_reg_readback: table of read vectors plus hand-written stall,
// snapshot, race-collision and reset sequences, checked through a byte scoreboard.
module tb_hedios_reg_readback;

  localparam int DEPTH    = 12;
  localparam int NUM_REGS = 3;
  localparam int ADDR_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_addr = '0;
  logic [NUM_REGS*DEPTH-1:0] reg_bus;
  logic [NUM_REGS-1:0]       reg_race = '0;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready = 1'b1;
  logic                      busy;

  logic [DEPTH-1:0] regs [NUM_REGS];
  assign reg_bus = {regs[2], regs[1], regs[0]};

  hedios_reg_readback #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .reg_bus(reg_bus), .reg_race(reg_race),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  logic rand_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Byte monitor at negedge: pops on accept, checks hold while stalled.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else if (tx_valid) begin
      if (hold_pend) check("hold_data", int'(tx_data), int'(hold_data));
      if (tx_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) check("unexpected_byte", int'(tx_data), -1);
        else check("byte", int'(tx_data), int'(exp_q.pop_front()));
      end else begin
        hold_pend = 1'b1;
        hold_data = tx_data;
      end
    end else begin
      if (hold_pend) check("valid_dropped", 0, 1);
      hold_pend = 1'b0;
    end
  end

  task automatic pulse_race(input int idx);
    @(posedge clk); #1;
    reg_race[idx] = 1'b1;
    @(posedge clk); #1;
    reg_race = '0;
  endtask

  task automatic start_read(input int addr, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
    int k = 0;
    @(posedge clk); #1;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("req_ready_wait", k < 50 ? 1 : 0, 1);
    exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(addr);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("latency_valid", int'(tx_valid), 1);
  endtask

  task automatic wait_done(input int exp_cycles);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check("frame_timeout", k < 300 ? 1 : 0, 1);
    if (exp_cycles > 0) check("frame_cycles", k, exp_cycles);
    check("ready_after", int'(req_ready), 1);
    check("valid_after", int'(tx_valid), 0);
  endtask

  typedef struct {
    int         addr;
    int         race_idx;   // -1: no pulse before the read
    int         n;
    logic [7:0] b0, b1, b2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, -1, 3, 8'h01, 8'h0A, 8'hBC};
    vecs[1] = '{2,  2, 3, 8'h82, 8'h00, 8'h05};
    vecs[2] = '{2, -1, 3, 8'h02, 8'h00, 8'h05};
    vecs[3] = '{3, -1, 1, 8'h43, 8'h00, 8'h00};
    vecs[4] = '{0, -1, 3, 8'h00, 8'h03, 8'hC5};
    vecs[5] = '{3,  0, 1, 8'h43, 8'h00, 8'h00};
    vecs[6] = '{0, -1, 3, 8'h80, 8'h03, 8'hC5};
    vecs[7] = '{0, -1, 3, 8'h00, 8'h03, 8'hC5};

    regs[0] = 12'h3C5;
    regs[1] = 12'hABC;
    regs[2] = 12'h005;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx_valid",  int'(tx_valid), 0);
    check("rst_tx_data",   int'(tx_data), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 1);

    foreach (vecs[i]) begin
      if (vecs[i].race_idx >= 0) pulse_race(vecs[i].race_idx);
      start_read(vecs[i].addr, vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2);
      wait_done(vecs[i].n);
    end

    // Random stalls with reg1 rewritten mid-frame; snapshot must survive.
    rand_mode = 1'b1;
    start_read(1, 3, 8'h01, 8'h0A, 8'hBC);
    @(posedge clk); #1;
    regs[1] = 12'h123;
    wait_done(0);
    rand_mode = 1'b0;
    @(posedge clk); #2;
    tx_ready = 1'b1;
    start_read(1, 3, 8'h01, 8'h01, 8'h23);
    wait_done(3);

    // Race pulse coincident with header accept of reg 0.
    tx_ready = 1'b0;
    start_read(0, 3, 8'h00, 8'h03, 8'hC5);
    repeat (2) @(posedge clk);
    #1;
    tx_ready    = 1'b1;
    reg_race[0] = 1'b1;
    @(posedge clk); #1;
    reg_race = '0;
    wait_done(0);
    start_read(0, 3, 8'h80, 8'h03, 8'hC5);
    wait_done(3);

    // Reset during DATA with a pending race flag on reg 1.
    pulse_race(1);
    tx_ready = 1'b0;
    start_read(0, 1, 8'h00, 8'h00, 8'h00);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("in_data_busy", int'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_valid", int'(tx_valid), 0);
    check("mid_rst_busy",  int'(busy), 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    start_read(1, 3, 8'h01, 8'h01, 8'h23);
    wait_done(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
